// File: rtl/br_amba_iso_resp_tracker_pkg.sv
// Shared AXI constants, FSM state type and width helper for the isolator response tracker.
package br_amba_iso_resp_tracker_pkg;

    localparam int unsigned AxiRespWidth = 2;
    localparam int unsigned AxiFullBurstLenWidth = 8;

    localparam logic [AxiRespWidth-1:0] AxiRespOkay   = 2'b00;
    localparam logic [AxiRespWidth-1:0] AxiRespSlverr = 2'b10;

    typedef enum logic [1:0] {
        StConnected = 2'd0,
        StDraining  = 2'd1,
        StIsolated  = 2'd2
    } iso_state_e;

    // A single-beat (AXI-Lite) configuration still needs a 1-bit length field.
    function automatic int unsigned clamped_clog2(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/br_amba_iso_resp_tracker_if.sv
// Upstream/downstream AW, AR, B and R handshake bundle around the isolator response tracker.
interface br_amba_iso_resp_tracker_if
    import br_amba_iso_resp_tracker_pkg::*;
#(
    parameter int unsigned IdWidth  = 1,
    parameter int unsigned LenWidth = AxiFullBurstLenWidth
);
    logic                    upstream_awvalid;
    logic                    upstream_awready;
    logic [IdWidth-1:0]      upstream_awid;
    logic                    downstream_awvalid;
    logic                    downstream_awready;

    logic                    upstream_arvalid;
    logic                    upstream_arready;
    logic [IdWidth-1:0]      upstream_arid;
    logic [LenWidth-1:0]     upstream_arlen;
    logic                    downstream_arvalid;
    logic                    downstream_arready;

    logic                    downstream_bvalid;
    logic                    downstream_bready;
    logic [IdWidth-1:0]      downstream_bid;
    logic [AxiRespWidth-1:0] downstream_bresp;
    logic                    upstream_bvalid;
    logic                    upstream_bready;
    logic [IdWidth-1:0]      upstream_bid;
    logic [AxiRespWidth-1:0] upstream_bresp;

    logic                    downstream_rvalid;
    logic                    downstream_rready;
    logic                    downstream_rlast;
    logic [IdWidth-1:0]      downstream_rid;
    logic [AxiRespWidth-1:0] downstream_rresp;
    logic                    upstream_rvalid;
    logic                    upstream_rready;
    logic                    upstream_rlast;
    logic [IdWidth-1:0]      upstream_rid;
    logic [AxiRespWidth-1:0] upstream_rresp;

    // The tracker itself sits on the slave side of this bundle.
    modport slave (
        input  upstream_awvalid, upstream_awid, downstream_awready,
        output upstream_awready, downstream_awvalid,
        input  upstream_arvalid, upstream_arid, upstream_arlen, downstream_arready,
        output upstream_arready, downstream_arvalid,
        input  downstream_bvalid, downstream_bid, downstream_bresp, upstream_bready,
        output downstream_bready, upstream_bvalid, upstream_bid, upstream_bresp,
        input  downstream_rvalid, downstream_rlast, downstream_rid, downstream_rresp,
        input  upstream_rready,
        output downstream_rready, upstream_rvalid, upstream_rlast, upstream_rid, upstream_rresp
    );

    modport master (
        output upstream_awvalid, upstream_awid, downstream_awready,
        input  upstream_awready, downstream_awvalid,
        output upstream_arvalid, upstream_arid, upstream_arlen, downstream_arready,
        input  upstream_arready, downstream_arvalid,
        output downstream_bvalid, downstream_bid, downstream_bresp, upstream_bready,
        input  downstream_bready, upstream_bvalid, upstream_bid, upstream_bresp,
        output downstream_rvalid, downstream_rlast, downstream_rid, downstream_rresp,
        output upstream_rready,
        input  downstream_rready, upstream_rvalid, upstream_rlast, upstream_rid, upstream_rresp
    );

endinterface

// File: rtl/br_amba_iso_resp_tracker_rlast_gen.sv
// Beat counter for the burst at the head of the read tracker; flags the final beat of that burst.
module br_amba_iso_rlast_gen #(
    parameter int unsigned LenWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                beat,
    input  logic                beat_last,
    input  logic [LenWidth-1:0] head_len,
    output logic                last
);

    logic [LenWidth-1:0] count_q;

    assign last = (count_q == head_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (beat) begin
            count_q <= beat_last ? '0 : count_q + LenWidth'(1);
        end
    end

endmodule

// File: rtl/br_amba_iso_resp_tracker.sv
// Tracks in-flight AW/AR requests and, on isolation, sinks downstream responses while
// synthesizing error B/R responses upstream for every outstanding transaction.
module br_amba_iso_resp_tracker
    import br_amba_iso_resp_tracker_pkg::*;
#(
    parameter int unsigned MaxOutstanding   = 2,
    parameter int unsigned MaxAxiBurstLen   = 2 ** AxiFullBurstLenWidth,
    parameter int unsigned AxiBurstLenWidth = clamped_clog2(MaxAxiBurstLen),
    parameter int unsigned IdWidth          = 1,
    parameter logic [AxiRespWidth-1:0] FakeResp = AxiRespSlverr
) (
    input  logic                           clk,
    input  logic                           rst,
    br_amba_iso_resp_tracker_if.slave      bus,
    input  logic                           isolate_req,
    output logic                           isolate_done
);

    localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

    typedef struct packed {
        logic [IdWidth-1:0]          id;
        logic [AxiBurstLenWidth-1:0] len;
    } r_entry_t;

    iso_state_e state_q, state_d;

    logic fwd_ok;
    logic b_push, b_pop, b_full, b_empty;
    logic r_push, r_pop, r_full, r_empty, r_beat;
    logic rlast_cmp;

    logic [IdWidth-1:0]  b_mem_q [MaxOutstanding];
    logic [PtrWidth-1:0] b_wr_q, b_rd_q;
    logic [CntWidth-1:0] b_cnt_q;
    r_entry_t            r_mem_q [MaxOutstanding];
    logic [PtrWidth-1:0] r_wr_q, r_rd_q;
    logic [CntWidth-1:0] r_cnt_q;
    logic [IdWidth-1:0]  b_head_id;
    r_entry_t            r_head;

    // Requests are blocked from the very cycle isolate_req is seen.
    assign fwd_ok = (state_q == StConnected) && !isolate_req;

    assign bus.downstream_awvalid = bus.upstream_awvalid && fwd_ok && !b_full;
    assign bus.upstream_awready   = bus.downstream_awready && fwd_ok && !b_full;
    assign bus.downstream_arvalid = bus.upstream_arvalid && fwd_ok && !r_full;
    assign bus.upstream_arready   = bus.downstream_arready && fwd_ok && !r_full;

    assign b_push = bus.downstream_awvalid && bus.downstream_awready;
    assign r_push = bus.downstream_arvalid && bus.downstream_arready;
    assign b_pop  = bus.upstream_bvalid && bus.upstream_bready && !b_empty;
    assign r_beat = bus.upstream_rvalid && bus.upstream_rready;
    assign r_pop  = r_beat && bus.upstream_rlast && !r_empty;

    assign b_full    = (b_cnt_q == FullCnt);
    assign b_empty   = (b_cnt_q == '0);
    assign r_full    = (r_cnt_q == FullCnt);
    assign r_empty   = (r_cnt_q == '0);
    assign b_head_id = b_mem_q[b_rd_q];
    assign r_head    = r_mem_q[r_rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            b_wr_q  <= '0;
            b_rd_q  <= '0;
            b_cnt_q <= '0;
            r_wr_q  <= '0;
            r_rd_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            if (b_push) b_wr_q <= (b_wr_q == LastPtr) ? '0 : b_wr_q + PtrWidth'(1);
            if (b_pop)  b_rd_q <= (b_rd_q == LastPtr) ? '0 : b_rd_q + PtrWidth'(1);
            if (r_push) r_wr_q <= (r_wr_q == LastPtr) ? '0 : r_wr_q + PtrWidth'(1);
            if (r_pop)  r_rd_q <= (r_rd_q == LastPtr) ? '0 : r_rd_q + PtrWidth'(1);
            b_cnt_q <= b_cnt_q + CntWidth'(b_push) - CntWidth'(b_pop);
            r_cnt_q <= r_cnt_q + CntWidth'(r_push) - CntWidth'(r_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (b_push) b_mem_q[b_wr_q] <= bus.upstream_awid;
        if (r_push) r_mem_q[r_wr_q] <= {bus.upstream_arid, bus.upstream_arlen};
    end

    br_amba_iso_rlast_gen #(
        .LenWidth (AxiBurstLenWidth)
    ) u_rlast_gen (
        .clk       (clk),
        .rst       (rst),
        .beat      (r_beat),
        .beat_last (bus.upstream_rlast),
        .head_len  (r_head.len),
        .last      (rlast_cmp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StConnected;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StConnected: if (isolate_req) state_d = StDraining;
            StDraining:  if (b_empty && r_empty) state_d = StIsolated;
            StIsolated:  if (!isolate_req) state_d = StConnected;
            default:     state_d = StConnected;
        endcase
    end

    always_comb begin
        bus.upstream_bvalid   = 1'b0;
        bus.upstream_bid      = '0;
        bus.upstream_bresp    = '0;
        bus.downstream_bready = 1'b1;
        bus.upstream_rvalid   = 1'b0;
        bus.upstream_rlast    = 1'b0;
        bus.upstream_rid      = '0;
        bus.upstream_rresp    = '0;
        bus.downstream_rready = 1'b1;
        unique case (state_q)
            StConnected: begin
                bus.upstream_bvalid   = bus.downstream_bvalid;
                bus.upstream_bid      = bus.downstream_bid;
                bus.upstream_bresp    = bus.downstream_bresp;
                bus.downstream_bready = bus.upstream_bready;
                bus.upstream_rvalid   = bus.downstream_rvalid;
                bus.upstream_rlast    = bus.downstream_rlast;
                bus.upstream_rid      = bus.downstream_rid;
                bus.upstream_rresp    = bus.downstream_rresp;
                bus.downstream_rready = bus.upstream_rready;
            end
            StDraining: begin
                bus.upstream_bvalid = !b_empty;
                bus.upstream_bid    = b_head_id;
                bus.upstream_bresp  = FakeResp;
                bus.upstream_rvalid = !r_empty;
                bus.upstream_rlast  = !r_empty && rlast_cmp;
                bus.upstream_rid    = r_head.id;
                bus.upstream_rresp  = FakeResp;
            end
            default: ;
        endcase
    end

    assign isolate_done = (state_q == StIsolated);

    a_bid_head: assert property (@(posedge clk) disable iff (rst)
        (state_q == StConnected && bus.downstream_bvalid && !b_empty)
        |-> (bus.downstream_bid == b_head_id));
    a_rid_head: assert property (@(posedge clk) disable iff (rst)
        (state_q == StConnected && bus.downstream_rvalid && !r_empty)
        |-> (bus.downstream_rid == r_head.id));
    a_rlast_cmp: assert property (@(posedge clk) disable iff (rst)
        (state_q == StConnected && bus.downstream_rvalid && !r_empty)
        |-> (bus.downstream_rlast == rlast_cmp));
    a_b_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
        (bus.upstream_bvalid && bus.upstream_bready) |-> !b_empty);
    a_r_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
        (bus.upstream_rvalid && bus.upstream_rready) |-> !r_empty);
    a_release_when_done: assert property (@(posedge clk) disable iff (rst)
        $fell(isolate_req) |-> isolate_done);

endmodule
